// File: rtl/tv80_pkg.sv
// Shared TV80 encodings: decoder prefix codes, instruction-set and index-register
// selectors, core-mode constants and a one-hot index helper.
package tv80_pkg;

  typedef enum logic [1:0] {
    PFX_NONE = 2'b00,
    PFX_CB   = 2'b01,
    PFX_ED   = 2'b10,
    PFX_XY   = 2'b11
  } prefix_e;

  typedef enum logic [1:0] {
    ISET_BASE = 2'b00,
    ISET_CB   = 2'b01,
    ISET_ED   = 2'b10
  } iset_e;

  typedef enum logic [1:0] {
    XY_HL = 2'b00,
    XY_IX = 2'b01,
    XY_IY = 2'b10
  } xy_e;

  localparam int MODE_Z80  = 0;
  localparam int MODE_FAST = 1;
  localparam int MODE_8080 = 2;
  localparam int MODE_GB   = 3;

  // 1-based position of the set bit in a one-hot vector (0 if no bit is set).
  function automatic logic [2:0] oh_index(input logic [6:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (oh[i]) idx = 3'(i + 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tv80_mcycle_seq_if.sv
// Decoder-to-sequencer bundle: decoder inputs and counter/prefix outputs.
interface tv80_mcycle_seq_if #(
  parameter int MAX_MCYC = 7
);
  logic                cen;
  logic                wait_n;
  logic [2:0]          mcycles;
  logic [2:0]          tstates;
  logic [1:0]          prefix;
  logic                ir5;
  logic [MAX_MCYC-1:0] mcycle;
  logic [6:0]          tstate;
  logic [1:0]          iset;
  logic [1:0]          xy_state;
  logic                last_t;
  logic                last_m;

  modport master (
    output cen, wait_n, mcycles, tstates, prefix, ir5,
    input  mcycle, tstate, iset, xy_state, last_t, last_m
  );

  modport slave (
    input  cen, wait_n, mcycles, tstates, prefix, ir5,
    output mcycle, tstate, iset, xy_state, last_t, last_m
  );
endinterface

// File: rtl/tv80_tstate_cnt.sv
// One-hot T-state counter with per-mode length override, minimum-length clamp
// and T2 wait-state hold.
module tv80_tstate_cnt
  import tv80_pkg::*;
#(
  parameter int Mode    = 0,
  parameter int WAIT_EN = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cen_i,
  input  logic       wait_n_i,
  input  logic [2:0] tstates_i,
  input  logic       is_m1_i,
  output logic [6:0] tstate_o,
  output logic       last_t_o,
  output logic       t_wrap_o
);

  logic [6:0] tstate_q, tstate_d;
  logic [2:0] teff;
  logic [2:0] tIdx;
  logic       waitHold;

  // Fast Z80 and GB run fixed-length non-M1 cycles regardless of the decoder.
  always_comb begin
    teff = tstates_i;
    if (!is_m1_i && Mode == MODE_FAST) begin
      teff = 3'd3;
    end else if (!is_m1_i && Mode == MODE_GB) begin
      teff = 3'd4;
    end
    if (teff < 3'd3) teff = 3'd3;
  end

  always_comb begin
    tIdx     = oh_index(tstate_q);
    waitHold = cen_i && (WAIT_EN != 0) && tstate_q[1] && !wait_n_i;
    // Wrapping on >= keeps the counter one-hot if the decoder shortens a cycle late.
    t_wrap_o = cen_i && !waitHold && (tIdx >= teff);
    last_t_o = (tIdx == teff) && !waitHold;
    tstate_d = tstate_q;
    if (cen_i && !waitHold) begin
      if (tIdx >= teff) tstate_d = 7'b000_0001;
      else              tstate_d = tstate_q << 1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tstate_q <= 7'b000_0001;
    else          tstate_q <= tstate_d;
  end

  assign tstate_o = tstate_q;

endmodule

// File: rtl/tv80_mcycle_seq.sv
// TV80 machine-cycle sequencer: one-hot M-cycle counter and instruction-set /
// index-register prefix state, driven by the T-state counter's wrap pulse.
module tv80_mcycle_seq
  import tv80_pkg::*;
#(
  parameter int Mode     = 0,
  parameter int MAX_MCYC = 7,
  parameter int WAIT_EN  = 1
) (
  input logic               clk,
  input logic               reset_n,
  tv80_mcycle_seq_if.slave  bus
);

  logic [MAX_MCYC-1:0] mcycle_q, mcycle_d;
  logic [1:0]          iset_q, iset_d;
  logic [1:0]          xy_q, xy_d;
  logic [2:0]          meff;
  logic [2:0]          mIdx;
  logic                tWrap;
  logic                instrEnd;
  logic [6:0]          tstate;
  logic                lastT;

  tv80_tstate_cnt #(
    .Mode    (Mode),
    .WAIT_EN (WAIT_EN)
  ) u_tstate_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .cen_i     (bus.cen),
    .wait_n_i  (bus.wait_n),
    .tstates_i (bus.tstates),
    .is_m1_i   (mcycle_q[0]),
    .tstate_o  (tstate),
    .last_t_o  (lastT),
    .t_wrap_o  (tWrap)
  );

  always_comb begin
    meff = bus.mcycles;
    if (bus.mcycles == 3'd0) begin
      meff = 3'd1;
    end else if (int'(bus.mcycles) > MAX_MCYC) begin
      meff = 3'(MAX_MCYC);
    end
  end

  always_comb begin
    mIdx     = oh_index(7'(mcycle_q));
    instrEnd = tWrap && (mIdx >= meff);
    mcycle_d = mcycle_q;
    if (instrEnd)   mcycle_d = MAX_MCYC'(1);
    else if (tWrap) mcycle_d = mcycle_q << 1;
  end

  // CB keeps the index selection so DDCB/FDCB still address IX/IY.
  always_comb begin
    iset_d = iset_q;
    xy_d   = xy_q;
    if (instrEnd) begin
      case (bus.prefix)
        PFX_NONE: begin iset_d = ISET_BASE; xy_d = XY_HL; end
        PFX_CB:   begin iset_d = ISET_CB; end
        PFX_ED:   begin iset_d = ISET_ED;   xy_d = XY_HL; end
        default:  begin iset_d = ISET_BASE; xy_d = bus.ir5 ? XY_IY : XY_IX; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcycle_q <= MAX_MCYC'(1);
      iset_q   <= ISET_BASE;
      xy_q     <= XY_HL;
    end else begin
      mcycle_q <= mcycle_d;
      iset_q   <= iset_d;
      xy_q     <= xy_d;
    end
  end

  assign bus.mcycle   = mcycle_q;
  assign bus.tstate   = tstate;
  assign bus.iset     = iset_q;
  assign bus.xy_state = xy_q;
  assign bus.last_t   = lastT;
  assign bus.last_m   = (mIdx == meff);

endmodule

// File: tb/tb_tv80_mcycle_seq.sv
// Directed bench for tv80_mcycle_seq: four instances (Z80, Z80 without waits and
// 3-deep M counter, fast Z80, GB) share one set of decoder inputs.
module tb_tv80_mcycle_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       cen, wait_n, ir5;
  logic [2:0] mcycles, tstates;
  logic [1:0] prefix;
  int         vectors = 0;
  int         miscompares = 0;

  tv80_mcycle_seq_if #(.MAX_MCYC(7)) ifA ();
  tv80_mcycle_seq_if #(.MAX_MCYC(3)) ifN ();
  tv80_mcycle_seq_if #(.MAX_MCYC(7)) ifF ();
  tv80_mcycle_seq_if #(.MAX_MCYC(7)) ifG ();

  assign {ifA.cen, ifA.wait_n, ifA.mcycles, ifA.tstates, ifA.prefix, ifA.ir5} = {cen, wait_n, mcycles, tstates, prefix, ir5};
  assign {ifN.cen, ifN.wait_n, ifN.mcycles, ifN.tstates, ifN.prefix, ifN.ir5} = {cen, wait_n, mcycles, tstates, prefix, ir5};
  assign {ifF.cen, ifF.wait_n, ifF.mcycles, ifF.tstates, ifF.prefix, ifF.ir5} = {cen, wait_n, mcycles, tstates, prefix, ir5};
  assign {ifG.cen, ifG.wait_n, ifG.mcycles, ifG.tstates, ifG.prefix, ifG.ir5} = {cen, wait_n, mcycles, tstates, prefix, ir5};

  tv80_mcycle_seq #(.Mode(0), .MAX_MCYC(7), .WAIT_EN(1)) dutA (.clk(clk), .reset_n(reset_n), .bus(ifA));
  tv80_mcycle_seq #(.Mode(0), .MAX_MCYC(3), .WAIT_EN(0)) dutN (.clk(clk), .reset_n(reset_n), .bus(ifN));
  tv80_mcycle_seq #(.Mode(1), .MAX_MCYC(7), .WAIT_EN(1)) dutF (.clk(clk), .reset_n(reset_n), .bus(ifF));
  tv80_mcycle_seq #(.Mode(3), .MAX_MCYC(7), .WAIT_EN(1)) dutG (.clk(clk), .reset_n(reset_n), .bus(ifG));

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    cen     = 1'b1;
    wait_n  = 1'b1;
    prefix  = 2'b00;
    ir5     = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [19:0] got, exp;
    cen = 1'b0; wait_n = 1'b1; mcycles = 3'd1; tstates = 3'd4; prefix = 2'b00; ir5 = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    got = {ifA.mcycle, ifA.tstate, ifA.iset, ifA.xy_state, ifA.last_t, ifA.last_m};
    exp = {7'd1, 7'd1, 2'b00, 2'b00, 1'b0, 1'b1};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL reset_state: got %b expected %b", got, exp);
    end
    cen = 1'b1;
    cycle();
    #1;
    vectors++;
    if ({ifN.mcycle, ifN.tstate} !== {3'd1, 7'd1}) begin
      miscompares++;
      $display("FAIL reset_hold_n: got %b expected %b", {ifN.mcycle, ifN.tstate}, {3'd1, 7'd1});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_tstate_walk();
    logic [14:0] got, exp;
    mcycles = 3'd1; tstates = 3'd4; cen = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      got = {ifA.tstate, ifA.last_t, ifA.mcycle};
      exp = {7'(1 << (i % 4)), (i % 4) == 3, 7'd1};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL walk[%0d]: got %b expected %b", i, got, exp);
      end
      cycle();
    end
  endtask

  task automatic test_three_cycle();
    int eM[10]  = '{1, 1, 1, 1, 2, 2, 2, 4, 4, 4};
    int eT[10]  = '{1, 2, 4, 8, 1, 2, 4, 1, 2, 4};
    int eLT[10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    int eLM[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    logic [15:0] got, exp;
    apply_reset();
    mcycles = 3'd3;
    for (int i = 0; i < 11; i++) begin
      tstates = (eM[i % 10] == 1) ? 3'd4 : 3'd3;
      #1;
      got = {ifA.mcycle, ifA.tstate, ifA.last_t, ifA.last_m};
      exp = {7'(eM[i % 10]), 7'(eT[i % 10]), 1'(eLT[i % 10]), 1'(eLM[i % 10])};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL three_cycle[%0d]: got %b expected %b", i, got, exp);
      end
      cycle();
    end
  endtask

  task automatic test_wait();
    int aM[9] = '{1, 1, 1, 2, 2, 2, 2, 2, 4};
    int aT[9] = '{1, 2, 4, 1, 2, 2, 2, 4, 1};
    int aL[9] = '{0, 0, 1, 0, 0, 0, 0, 1, 0};
    int nM[9] = '{1, 1, 1, 2, 2, 2, 4, 4, 4};
    int nT[9] = '{1, 2, 4, 1, 2, 4, 1, 2, 4};
    int nL[9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
    logic [14:0] gotA, expA;
    logic [10:0] gotN, expN;
    apply_reset();
    mcycles = 3'd3; tstates = 3'd3;
    for (int i = 0; i < 9; i++) begin
      wait_n = !(i == 4 || i == 5 || i == 7);
      #1;
      gotA = {ifA.mcycle, ifA.tstate, ifA.last_t};
      expA = {7'(aM[i]), 7'(aT[i]), 1'(aL[i])};
      vectors++;
      if (gotA !== expA) begin
        miscompares++;
        $display("FAIL wait_en[%0d]: got %b expected %b", i, gotA, expA);
      end
      gotN = {ifN.mcycle, ifN.tstate, ifN.last_t};
      expN = {3'(nM[i]), 7'(nT[i]), 1'(nL[i])};
      vectors++;
      if (gotN !== expN) begin
        miscompares++;
        $display("FAIL wait_off[%0d]: got %b expected %b", i, gotN, expN);
      end
      cycle();
    end
    wait_n = 1'b1;
  endtask

  task automatic test_mode_override();
    int fM[11] = '{1, 1, 1, 1, 1, 1, 2, 2, 2, 1, 1};
    int fT[11] = '{1, 2, 4, 8, 16, 32, 1, 2, 4, 1, 2};
    int fL[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
    int gM[11] = '{1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 1};
    int gT[11] = '{1, 2, 4, 8, 16, 32, 1, 2, 4, 8, 1};
    int gL[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
    logic [14:0] got, exp;
    apply_reset();
    mcycles = 3'd2; tstates = 3'd6;
    for (int i = 0; i < 11; i++) begin
      #1;
      got = {ifF.mcycle, ifF.tstate, ifF.last_t};
      exp = {7'(fM[i]), 7'(fT[i]), 1'(fL[i])};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL mode_fast[%0d]: got %b expected %b", i, got, exp);
      end
      got = {ifG.mcycle, ifG.tstate, ifG.last_t};
      exp = {7'(gM[i]), 7'(gT[i]), 1'(gL[i])};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL mode_gb[%0d]: got %b expected %b", i, got, exp);
      end
      cycle();
    end
  endtask

  task automatic test_clamp();
    int eT[4]   = '{1, 2, 4, 1};
    int nM[10]  = '{1, 1, 1, 2, 2, 2, 4, 4, 4, 1};
    logic [15:0] got, exp;
    logic [3:0]  gotN, expN;
    apply_reset();
    mcycles = 3'd0; tstates = 3'd1;
    for (int i = 0; i < 4; i++) begin
      #1;
      got = {ifA.mcycle, ifA.tstate, ifA.last_t, ifA.last_m};
      exp = {7'd1, 7'(eT[i]), i == 2, 1'b1};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL clamp_low[%0d]: got %b expected %b", i, got, exp);
      end
      cycle();
    end
    apply_reset();
    mcycles = 3'd5; tstates = 3'd3;
    for (int i = 0; i < 10; i++) begin
      #1;
      gotN = {ifN.mcycle, ifN.last_m};
      expN = {3'(nM[i]), (i >= 6 && i <= 8)};
      vectors++;
      if (gotN !== expN) begin
        miscompares++;
        $display("FAIL clamp_high[%0d]: got %b expected %b", i, gotN, expN);
      end
      if (i == 9) begin
        vectors++;
        if ({ifA.mcycle, ifA.tstate} !== {7'd8, 7'd1}) begin
          miscompares++;
          $display("FAIL clamp_deep: got %b expected %b", {ifA.mcycle, ifA.tstate}, {7'd8, 7'd1});
        end
      end
      cycle();
    end
  endtask

  task automatic test_prefix();
    logic [1:0] pfx[7]  = '{2'b11, 2'b01, 2'b00, 2'b11, 2'b10, 2'b11, 2'b11};
    logic       pir5[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] eIX[7]  = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] prev;
    logic [17:0] got, exp;
    apply_reset();
    mcycles = 3'd1; tstates = 3'd3;
    prev = 4'b0000;
    for (int k = 0; k < 7; k++) begin
      prefix = pfx[k];
      ir5    = pir5[k];
      cycle();
      cycle();
      #1;
      got = {12'd0, ifA.iset, ifA.xy_state, ifA.last_t, ifA.last_m};
      exp = {12'd0, prev, 1'b1, 1'b1};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL prefix_hold[%0d]: got %b expected %b", k, got, exp);
      end
      cycle();
      #1;
      got = {ifA.iset, ifA.xy_state, ifA.tstate, ifA.mcycle};
      exp = {eIX[k], 7'd1, 7'd1};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL prefix_end[%0d]: got %b expected %b", k, got, exp);
      end
      prev = eIX[k];
    end
    prefix = 2'b00; ir5 = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [17:0] got, exp;
    apply_reset();
    mcycles = 3'd1; tstates = 3'd3; prefix = 2'b11; ir5 = 1'b1;
    repeat (3) cycle();
    prefix = 2'b01;
    repeat (3) cycle();
    prefix = 2'b00; mcycles = 3'd3;
    repeat (7) cycle();
    wait_n = 1'b0;
    #1;
    got = {ifA.mcycle, ifA.tstate, ifA.iset, ifA.xy_state};
    exp = {7'd4, 7'd2, 2'b01, 2'b10};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL pre_reset_m3t2: got %b expected %b", got, exp);
    end
    cycle();
    cen = 1'b0; wait_n = 1'b1;
    cycle();
    #1;
    vectors++;
    if ({ifA.mcycle, ifA.tstate} !== {7'd4, 7'd2}) begin
      miscompares++;
      $display("FAIL cen_freeze: got %b expected %b", {ifA.mcycle, ifA.tstate}, {7'd4, 7'd2});
    end
    cen = 1'b1; wait_n = 1'b0;
    cycle();
    cen = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    got = {ifA.mcycle, ifA.tstate, ifA.iset, ifA.xy_state};
    exp = {7'd1, 7'd1, 2'b00, 2'b00};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL async_reset: got %b expected %b", got, exp);
    end
    vectors++;
    if ({ifA.last_t, ifA.last_m} !== 2'b00) begin
      miscompares++;
      $display("FAIL async_reset_last: got %b expected %b", {ifA.last_t, ifA.last_m}, 2'b00);
    end
    cen = 1'b1; wait_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_tstate_walk();
    test_three_cycle();
    test_wait();
    test_mode_override();
    test_clamp();
    test_prefix();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
